// File: rtl/decode_stage_riscv.sv
// decode_stage_riscv: RV32I + Zicsr + mret decoder feeding a DEPTH-entry FIFO
// of decoded bundles. Decode happens on instr_i at push time; all outputs come
// from the stored head entry. Define RV32M_EN to also decode the RV32M group.

package decode_stage_riscv_pkg;

    typedef enum logic [6:0] {
        OPC_LOAD     = 7'b0000011,
        OPC_MISC_MEM = 7'b0001111,
        OPC_OP_IMM   = 7'b0010011,
        OPC_AUIPC    = 7'b0010111,
        OPC_STORE    = 7'b0100011,
        OPC_OP       = 7'b0110011,
        OPC_LUI      = 7'b0110111,
        OPC_BRANCH   = 7'b1100011,
        OPC_JALR     = 7'b1100111,
        OPC_JAL      = 7'b1101111,
        OPC_SYSTEM   = 7'b1110011
    } opcode_e;

    typedef enum logic [1:0] {A_RS1 = 2'd0, A_PC = 2'd1, A_ZERO = 2'd2, A_ZIMM = 2'd3} a_sel_e;

    typedef enum logic [2:0] {
        B_RS2 = 3'd0, B_IMM_I = 3'd1, B_IMM_S = 3'd2, B_IMM_U = 3'd3, B_IMM_J = 3'd4
    } b_sel_e;

    typedef enum logic [4:0] {
        ALU_ADD = 5'd0,  ALU_SUB = 5'd1,  ALU_SLL = 5'd2,  ALU_SLT = 5'd3,
        ALU_SLTU = 5'd4, ALU_XOR = 5'd5,  ALU_SRL = 5'd6,  ALU_SRA = 5'd7,
        ALU_OR = 5'd8,   ALU_AND = 5'd9,  ALU_EQ = 5'd10,  ALU_NE = 5'd11,
        ALU_LT = 5'd12,  ALU_GE = 5'd13,  ALU_LTU = 5'd14, ALU_GEU = 5'd15
    } alu_op_e;

    typedef enum logic [2:0] {CSR_RW = 3'd0, CSR_RS = 3'd1, CSR_RC = 3'd2} csr_op_e;

    // Load/store size encoding equals the instruction funct3
    typedef enum logic [2:0] {
        LDST_B = 3'd0, LDST_H = 3'd1, LDST_W = 3'd2, LDST_BU = 3'd4, LDST_HU = 3'd5
    } mem_size_e;

    typedef enum logic [1:0] {
        WB_EX_RESULT = 2'd0, WB_LSU_DATA = 2'd1, WB_CSR_DATA = 2'd2, WB_PC_NEXT = 2'd3
    } wb_sel_e;

    typedef struct packed {
        a_sel_e      a_sel;
        b_sel_e      b_sel;
        alu_op_e     alu_op;
        csr_op_e     csr_op;
        mem_size_e   mem_size;
        wb_sel_e     wb_sel;
        logic        csr_we;
        logic        mem_req;
        logic        mem_we;
        logic        gpr_we;
        logic        illegal;
        logic        branch;
        logic        jal;
        logic        jalr;
        logic        mret;
`ifdef RV32M_EN
        logic        mdu_req;
        logic [2:0]  mdu_op;
`endif
        logic [31:0] instr;
        logic [31:0] pc;
    } dec_t;

endpackage

module decode_stage_riscv
    import decode_stage_riscv_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [31:0] instr_i,
    input  logic [31:0] pc_i,
    input  logic        in_valid_i,
    output logic        in_ready_o,
    input  logic        flush_i,
    output logic        out_valid_o,
    input  logic        out_ready_i,
    output logic [31:0] instr_o,
    output logic [31:0] pc_o,
    output logic [1:0]  a_sel_o,
    output logic [2:0]  b_sel_o,
    output logic [4:0]  alu_op_o,
    output logic [2:0]  csr_op_o,
    output logic [2:0]  mem_size_o,
    output logic [1:0]  wb_sel_o,
    output logic        csr_we_o,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic        gpr_we_o,
    output logic        illegal_instr_o,
    output logic        branch_o,
    output logic        jal_o,
    output logic        jalr_o,
    output logic        mret_o,
    output logic        mdu_req_o,
    output logic [2:0]  mdu_op_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    dec_t             r_mem [DEPTH];

    logic [6:0] w_opcode;
    logic [2:0] w_f3;
    logic [6:0] w_f7;
    logic       w_legal;
    dec_t       w_dec;
    dec_t       w_head;
    logic       w_push;
    logic       w_pop;

    function automatic dec_t dec_default(input logic [31:0] instr, input logic [31:0] pc);
        dec_t d;
        d          = '0;
        d.a_sel    = A_RS1;
        d.b_sel    = B_IMM_I;
        d.alu_op   = ALU_ADD;
        d.csr_op   = CSR_RW;
        d.mem_size = LDST_B;
        d.wb_sel   = WB_EX_RESULT;
        d.instr    = instr;
        d.pc       = pc;
        return d;
    endfunction

    function automatic alu_op_e alu_arith(input logic [2:0] f3, input logic alt);
        case (f3)
            3'd0:    return alt ? ALU_SUB : ALU_ADD;
            3'd1:    return ALU_SLL;
            3'd2:    return ALU_SLT;
            3'd3:    return ALU_SLTU;
            3'd4:    return ALU_XOR;
            3'd5:    return alt ? ALU_SRA : ALU_SRL;
            3'd6:    return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction

    assign w_opcode = instr_i[6:0];
    assign w_f3     = instr_i[14:12];
    assign w_f7     = instr_i[31:25];

    // Combinational decode of the incoming word into a full bundle
    always_comb begin
        w_legal = 1'b1;
        w_dec   = dec_default(instr_i, pc_i);
        case (w_opcode)
            OPC_LUI: begin
                w_dec.a_sel  = A_ZERO;
                w_dec.b_sel  = B_IMM_U;
                w_dec.gpr_we = 1'b1;
            end
            OPC_AUIPC: begin
                w_dec.a_sel  = A_PC;
                w_dec.b_sel  = B_IMM_U;
                w_dec.gpr_we = 1'b1;
            end
            OPC_JAL: begin
                w_dec.a_sel  = A_PC;
                w_dec.b_sel  = B_IMM_J;
                w_dec.wb_sel = WB_PC_NEXT;
                w_dec.jal    = 1'b1;
                w_dec.gpr_we = 1'b1;
            end
            OPC_JALR: begin
                w_legal      = (w_f3 == 3'd0);
                w_dec.wb_sel = WB_PC_NEXT;
                w_dec.jalr   = 1'b1;
                w_dec.gpr_we = 1'b1;
            end
            OPC_BRANCH: begin
                w_legal      = !(w_f3 inside {3'd2, 3'd3});
                w_dec.b_sel  = B_RS2;
                w_dec.branch = 1'b1;
                case (w_f3)
                    3'd0:    w_dec.alu_op = ALU_EQ;
                    3'd1:    w_dec.alu_op = ALU_NE;
                    3'd4:    w_dec.alu_op = ALU_LT;
                    3'd5:    w_dec.alu_op = ALU_GE;
                    3'd6:    w_dec.alu_op = ALU_LTU;
                    default: w_dec.alu_op = ALU_GEU;
                endcase
            end
            OPC_LOAD: begin
                w_legal        = w_f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
                w_dec.mem_req  = 1'b1;
                w_dec.gpr_we   = 1'b1;
                w_dec.mem_size = mem_size_e'(w_f3);
                w_dec.wb_sel   = WB_LSU_DATA;
            end
            OPC_STORE: begin
                w_legal        = w_f3 inside {3'd0, 3'd1, 3'd2};
                w_dec.b_sel    = B_IMM_S;
                w_dec.mem_req  = 1'b1;
                w_dec.mem_we   = 1'b1;
                w_dec.mem_size = mem_size_e'(w_f3);
            end
            OPC_OP_IMM: begin
                w_dec.gpr_we = 1'b1;
                w_dec.alu_op = alu_arith(w_f3, (w_f3 == 3'd5) && (w_f7 == 7'h20));
                if (w_f3 == 3'd1) begin
                    w_legal = (w_f7 == 7'h00);
                end else if (w_f3 == 3'd5) begin
                    w_legal = (w_f7 == 7'h00) || (w_f7 == 7'h20);
                end
            end
            OPC_OP: begin
                w_dec.b_sel  = B_RS2;
                w_dec.gpr_we = 1'b1;
                if (w_f7 == 7'h00) begin
                    w_dec.alu_op = alu_arith(w_f3, 1'b0);
                end else if ((w_f7 == 7'h20) && ((w_f3 == 3'd0) || (w_f3 == 3'd5))) begin
                    w_dec.alu_op = alu_arith(w_f3, 1'b1);
                end else if (w_f7 == 7'h01) begin
`ifdef RV32M_EN
                    w_dec.mdu_req = 1'b1;
                    w_dec.mdu_op  = w_f3;
`else
                    w_legal = 1'b0;
`endif
                end else begin
                    w_legal = 1'b0;
                end
            end
            OPC_MISC_MEM: begin
                w_legal = (w_f3 == 3'd0);
            end
            OPC_SYSTEM: begin
                if (w_f3 == 3'd0) begin
                    w_legal    = (w_f7 == 7'h18);
                    w_dec.mret = 1'b1;
                end else if (w_f3 == 3'd4) begin
                    w_legal = 1'b0;
                end else begin
                    w_dec.csr_we = 1'b1;
                    w_dec.gpr_we = 1'b1;
                    w_dec.wb_sel = WB_CSR_DATA;
                    w_dec.a_sel  = w_f3[2] ? A_ZIMM : A_RS1;
                    case (w_f3[1:0])
                        2'b01:   w_dec.csr_op = CSR_RW;
                        2'b10:   w_dec.csr_op = CSR_RS;
                        default: w_dec.csr_op = CSR_RC;
                    endcase
                end
            end
            default: w_legal = 1'b0;
        endcase
        // Illegal words discard everything decoded above and keep only the flag
        if (!w_legal) begin
            w_dec         = dec_default(instr_i, pc_i);
            w_dec.illegal = 1'b1;
        end
    end

    assign in_ready_o  = (r_count != CNT_W'(DEPTH));
    assign out_valid_o = (r_count != '0);
    assign w_push      = in_valid_i & in_ready_o & ~flush_i;
    assign w_pop       = out_valid_o & out_ready_i & ~flush_i;

    // Pointer and occupancy tracking; reset and flush both empty the buffer
    always_ff @(posedge clk_i) begin
        if (rst_i || flush_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            if (w_push && !w_pop) begin
                r_count <= r_count + 1'b1;
            end else if (!w_push && w_pop) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

    // Payload storage; contents are only meaningful while counted as valid
    always_ff @(posedge clk_i) begin
        if (w_push) r_mem[r_wr_ptr] <= w_dec;
    end

    assign w_head          = r_mem[r_rd_ptr];
    assign instr_o         = w_head.instr;
    assign pc_o            = w_head.pc;
    assign a_sel_o         = w_head.a_sel;
    assign b_sel_o         = w_head.b_sel;
    assign alu_op_o        = w_head.alu_op;
    assign csr_op_o        = w_head.csr_op;
    assign mem_size_o      = w_head.mem_size;
    assign wb_sel_o        = w_head.wb_sel;
    assign csr_we_o        = out_valid_o & w_head.csr_we;
    assign mem_req_o       = out_valid_o & w_head.mem_req;
    assign mem_we_o        = out_valid_o & w_head.mem_we;
    assign gpr_we_o        = out_valid_o & w_head.gpr_we;
    assign illegal_instr_o = out_valid_o & w_head.illegal;
    assign branch_o        = out_valid_o & w_head.branch;
    assign jal_o           = out_valid_o & w_head.jal;
    assign jalr_o          = out_valid_o & w_head.jalr;
    assign mret_o          = out_valid_o & w_head.mret;
`ifdef RV32M_EN
    assign mdu_req_o       = out_valid_o & w_head.mdu_req;
    assign mdu_op_o        = w_head.mdu_op;
`else
    assign mdu_req_o       = 1'b0;
    assign mdu_op_o        = '0;
`endif

endmodule

// File: tb/tb_decode_stage_riscv.sv
// Self-checking bench for decode_stage_riscv: directed scenarios plus a
// randomized run against a queue-based reference model. Honours RV32M_EN.

module tb_decode_stage_riscv;
    import decode_stage_riscv_pkg::*;

    localparam int unsigned DEPTH = 2;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b0;
    logic [31:0] instr_i = '0;
    logic [31:0] pc_i = '0;
    logic        in_valid_i = 1'b0;
    logic        in_ready_o;
    logic        flush_i = 1'b0;
    logic        out_valid_o;
    logic        out_ready_i = 1'b0;
    logic [31:0] instr_o, pc_o;
    logic [1:0]  a_sel_o, wb_sel_o;
    logic [2:0]  b_sel_o, csr_op_o, mem_size_o, mdu_op_o;
    logic [4:0]  alu_op_o;
    logic        csr_we_o, mem_req_o, mem_we_o, gpr_we_o, illegal_instr_o;
    logic        branch_o, jal_o, jalr_o, mret_o, mdu_req_o;

    decode_stage_riscv #(.DEPTH(DEPTH)) u_dut (
        .clk_i(clk_i), .rst_i(rst_i), .instr_i(instr_i), .pc_i(pc_i),
        .in_valid_i(in_valid_i), .in_ready_o(in_ready_o), .flush_i(flush_i),
        .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
        .instr_o(instr_o), .pc_o(pc_o), .a_sel_o(a_sel_o), .b_sel_o(b_sel_o),
        .alu_op_o(alu_op_o), .csr_op_o(csr_op_o), .mem_size_o(mem_size_o),
        .wb_sel_o(wb_sel_o), .csr_we_o(csr_we_o), .mem_req_o(mem_req_o),
        .mem_we_o(mem_we_o), .gpr_we_o(gpr_we_o), .illegal_instr_o(illegal_instr_o),
        .branch_o(branch_o), .jal_o(jal_o), .jalr_o(jalr_o), .mret_o(mret_o),
        .mdu_req_o(mdu_req_o), .mdu_op_o(mdu_op_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct packed {
        logic [1:0] a;
        logic [2:0] b;
        logic [4:0] alu;
        logic [2:0] csr;
        logic [2:0] msz;
        logic [1:0] wb;
        logic csr_we, mem_req, mem_we, gpr_we, ill, br, jal, jalr, mret, mdu;
        logic [2:0] mdu_op;
    } exp_t;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
    } ent_t;

    ent_t q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    logic [9:0]  obs_en;
    logic [30:0] obs_all;
    assign obs_en  = {csr_we_o, mem_req_o, mem_we_o, gpr_we_o, illegal_instr_o,
                      branch_o, jal_o, jalr_o, mret_o, mdu_req_o};
    assign obs_all = {a_sel_o, b_sel_o, alu_op_o, csr_op_o, mem_size_o, wb_sel_o, obs_en, mdu_op_o};

    function automatic logic [9:0] exp_en(input exp_t e);
        return {e.csr_we, e.mem_req, e.mem_we, e.gpr_we, e.ill, e.br, e.jal, e.jalr, e.mret, e.mdu};
    endfunction

    function automatic logic [30:0] exp_all(input exp_t e);
        return {e.a, e.b, e.alu, e.csr, e.msz, e.wb, exp_en(e), e.mdu_op};
    endfunction

    function automatic exp_t base_exp();
        exp_t e;
        e = '0;
        e.a = A_RS1; e.b = B_IMM_I; e.alu = ALU_ADD; e.csr = CSR_RW;
        e.msz = LDST_B; e.wb = WB_EX_RESULT;
        return e;
    endfunction

    // Reference decode from the ISA rules: legality first, then field values
    function automatic exp_t ref_decode(input logic [31:0] ins);
        exp_t e;
        logic [6:0] op;
        logic [2:0] f3;
        logic [6:0] f7;
        bit ok;
        logic [4:0] arith [8];
        logic [4:0] cmp [8];
        arith = '{ALU_ADD, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_SRL, ALU_OR, ALU_AND};
        cmp   = '{ALU_EQ, ALU_NE, ALU_ADD, ALU_ADD, ALU_LT, ALU_GE, ALU_LTU, ALU_GEU};
        op = ins[6:0]; f3 = ins[14:12]; f7 = ins[31:25];
        e = base_exp();
        ok = 1;
        case (op)
            7'h37: begin e.a = A_ZERO; e.b = B_IMM_U; e.gpr_we = 1; end
            7'h17: begin e.a = A_PC; e.b = B_IMM_U; e.gpr_we = 1; end
            7'h6f: begin e.a = A_PC; e.b = B_IMM_J; e.wb = WB_PC_NEXT; e.jal = 1; e.gpr_we = 1; end
            7'h67: begin ok = (f3 == 0); e.wb = WB_PC_NEXT; e.jalr = 1; e.gpr_we = 1; end
            7'h63: begin ok = (f3 != 2 && f3 != 3); e.b = B_RS2; e.br = 1; e.alu = cmp[f3]; end
            7'h03: begin
                ok = (f3 == 0 || f3 == 1 || f3 == 2 || f3 == 4 || f3 == 5);
                e.mem_req = 1; e.gpr_we = 1; e.msz = f3; e.wb = WB_LSU_DATA;
            end
            7'h23: begin ok = (f3 <= 2); e.b = B_IMM_S; e.mem_req = 1; e.mem_we = 1; e.msz = f3; end
            7'h13: begin
                e.gpr_we = 1; e.alu = arith[f3];
                if (f3 == 1) ok = (f7 == 0);
                if (f3 == 5) begin
                    ok = (f7 == 0 || f7 == 7'h20);
                    if (f7 == 7'h20) e.alu = ALU_SRA;
                end
            end
            7'h33: begin
                e.b = B_RS2; e.gpr_we = 1;
                if (f7 == 0) e.alu = arith[f3];
                else if (f7 == 7'h20 && f3 == 0) e.alu = ALU_SUB;
                else if (f7 == 7'h20 && f3 == 5) e.alu = ALU_SRA;
                else if (f7 == 7'h01) begin
`ifdef RV32M_EN
                    e.mdu = 1; e.mdu_op = f3;
`else
                    ok = 0;
`endif
                end else ok = 0;
            end
            7'h0f: ok = (f3 == 0);
            7'h73: begin
                if (f3 == 0) begin ok = (f7 == 7'h18); e.mret = 1; end
                else if (f3 == 4) ok = 0;
                else begin
                    e.csr_we = 1; e.gpr_we = 1; e.wb = WB_CSR_DATA;
                    e.a = (f3 >= 4) ? A_ZIMM : A_RS1;
                    e.csr = (f3 % 4 == 1) ? CSR_RW : (f3 % 4 == 2) ? CSR_RS : CSR_RC;
                end
            end
            default: ok = 0;
        endcase
        if (!ok) begin
            e = base_exp();
            e.ill = 1;
        end
        return e;
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [31:0] w;
        w = $urandom;
        case ($urandom_range(0, 11))
            0: w[6:0] = 7'h37;  1: w[6:0] = 7'h17;  2: w[6:0] = 7'h6f;  3: w[6:0] = 7'h67;
            4: w[6:0] = 7'h63;  5: w[6:0] = 7'h03;  6: w[6:0] = 7'h23;  7: w[6:0] = 7'h13;
            8: w[6:0] = 7'h33;  9: w[6:0] = 7'h0f;  10: w[6:0] = 7'h73;
            default: ;
        endcase
        case ($urandom_range(0, 5))
            0: w[31:25] = 7'h00;  1: w[31:25] = 7'h20;
            2: w[31:25] = 7'h01;  3: w[31:25] = 7'h18;
            default: ;
        endcase
        return w;
    endfunction

    // Advance one clock and apply the same transfer to the reference queue
    task automatic tick();
        int  n;
        bit  push, pop;
        n    = q.size();
        push = in_valid_i && (n < DEPTH);
        pop  = out_ready_i && (n > 0);
        @(posedge clk_i);
        if (rst_i || flush_i) q.delete();
        else begin
            if (pop) void'(q.pop_front());
            if (push) q.push_back({instr_i, pc_i});
        end
        #1;
    endtask

    task automatic push_one(input logic [31:0] ins, input logic [31:0] pc);
        in_valid_i = 1; instr_i = ins; pc_i = pc;
        tick();
        in_valid_i = 0;
    endtask

    task automatic test_reset();
        rst_i = 1; in_valid_i = 0; flush_i = 0; out_ready_i = 0;
        tick();
        rst_i = 0;
        n_checks++; if (out_valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", out_valid_o); end
        n_checks++; if (in_ready_o !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b want 1", in_ready_o); end
        n_checks++; if (obs_en !== 10'b0) begin n_fail++; $display("FAIL reset_enables: got %b want 0", obs_en); end
    endtask

    task automatic test_add();
        logic [31:0] pc;
        exp_t e;
        pc = $urandom;
        e  = ref_decode(32'h002081B3);
        in_valid_i = 1; instr_i = 32'h002081B3; pc_i = pc; out_ready_i = 1;
        #1;
        n_checks++; if (out_valid_o !== 1'b0 || gpr_we_o !== 1'b0) begin n_fail++; $display("FAIL add_latency: got valid=%b gpr_we=%b want 0 0", out_valid_o, gpr_we_o); end
        tick();
        in_valid_i = 0;
        n_checks++; if (out_valid_o !== 1'b1) begin n_fail++; $display("FAIL add_valid: got %b want 1", out_valid_o); end
        n_checks++; if (gpr_we_o !== 1'b1) begin n_fail++; $display("FAIL add_gpr_we: got %b want 1", gpr_we_o); end
        n_checks++; if (b_sel_o !== B_RS2) begin n_fail++; $display("FAIL add_b_sel: got %0d want %0d", b_sel_o, B_RS2); end
        n_checks++; if (alu_op_o !== ALU_ADD) begin n_fail++; $display("FAIL add_alu_op: got %0d want %0d", alu_op_o, ALU_ADD); end
        n_checks++; if (pc_o !== pc) begin n_fail++; $display("FAIL add_pc: got %h want %h", pc_o, pc); end
        n_checks++; if (obs_all !== exp_all(e)) begin n_fail++; $display("FAIL add_bundle: got %h want %h", obs_all, exp_all(e)); end
        tick();
        out_ready_i = 0;
        n_checks++; if (out_valid_o !== 1'b0) begin n_fail++; $display("FAIL add_popped: got %b want 0", out_valid_o); end
    endtask

    task automatic test_mul();
        exp_t e;
        e = ref_decode(32'h022081B3);
        push_one(32'h022081B3, 32'h0000_1000);
`ifdef RV32M_EN
        n_checks++; if (mdu_req_o !== 1'b1 || mdu_op_o !== 3'd0 || illegal_instr_o !== 1'b0) begin
            n_fail++; $display("FAIL mul_m: got req=%b op=%0d ill=%b want 1 0 0", mdu_req_o, mdu_op_o, illegal_instr_o); end
`else
        n_checks++; if (illegal_instr_o !== 1'b1 || gpr_we_o !== 1'b0 || mdu_req_o !== 1'b0) begin
            n_fail++; $display("FAIL mul_illegal: got ill=%b gpr_we=%b mdu=%b want 1 0 0", illegal_instr_o, gpr_we_o, mdu_req_o); end
`endif
        n_checks++; if (obs_all !== exp_all(e)) begin n_fail++; $display("FAIL mul_bundle: got %h want %h", obs_all, exp_all(e)); end
        out_ready_i = 1; tick(); out_ready_i = 0;
    endtask

    task automatic test_full_order();
        logic [31:0] a, b, c;
        a = rand_instr(); b = rand_instr(); c = rand_instr();
        out_ready_i = 0;
        push_one(a, 32'h100);
        n_checks++; if (in_ready_o !== 1'b1) begin n_fail++; $display("FAIL full_ready1: got %b want 1", in_ready_o); end
        push_one(b, 32'h104);
        n_checks++; if (in_ready_o !== 1'b0) begin n_fail++; $display("FAIL full_ready2: got %b want 0", in_ready_o); end
        push_one(c, 32'h108);
        n_checks++; if (instr_o !== a || pc_o !== 32'h100) begin n_fail++; $display("FAIL full_head_stable: got %h/%h want %h/100", instr_o, pc_o, a); end
        out_ready_i = 1;
        tick();
        n_checks++; if (instr_o !== b || pc_o !== 32'h104) begin n_fail++; $display("FAIL full_second: got %h/%h want %h/104", instr_o, pc_o, b); end
        tick();
        out_ready_i = 0;
        n_checks++; if (out_valid_o !== 1'b0) begin n_fail++; $display("FAIL full_third_dropped: got valid %b want 0", out_valid_o); end
    endtask

    task automatic test_flush();
        out_ready_i = 0;
        push_one(rand_instr(), 32'h200);
        push_one(rand_instr(), 32'h204);
        flush_i = 1; out_ready_i = 1; in_valid_i = 1; instr_i = 32'h00000013; pc_i = 32'h208;
        tick();
        flush_i = 0; in_valid_i = 0;
        n_checks++; if (out_valid_o !== 1'b0 || in_ready_o !== 1'b1) begin n_fail++; $display("FAIL flush_empty: got valid=%b ready=%b want 0 1", out_valid_o, in_ready_o); end
        tick();
        out_ready_i = 0;
        n_checks++; if (out_valid_o !== 1'b0) begin n_fail++; $display("FAIL flush_push_ignored: got %b want 0", out_valid_o); end
    endtask

    task automatic test_system();
        exp_t e;
        e = ref_decode(32'h30200073);
        out_ready_i = 0;
        push_one(32'h30200073, 32'h300);
        push_one(32'h00004073, 32'h304);
        n_checks++; if (mret_o !== 1'b1 || illegal_instr_o !== 1'b0) begin n_fail++; $display("FAIL sys_mret: got mret=%b ill=%b want 1 0", mret_o, illegal_instr_o); end
        n_checks++; if (obs_all !== exp_all(e)) begin n_fail++; $display("FAIL sys_mret_bundle: got %h want %h", obs_all, exp_all(e)); end
        out_ready_i = 1;
        tick();
        n_checks++; if (illegal_instr_o !== 1'b1 || csr_we_o !== 1'b0 || mret_o !== 1'b0) begin
            n_fail++; $display("FAIL sys_f3_4: got ill=%b csr_we=%b mret=%b want 1 0 0", illegal_instr_o, csr_we_o, mret_o); end
        tick();
        out_ready_i = 0;
    endtask

    task automatic test_reset_mid();
        logic [31:0] x;
        x = rand_instr();
        out_ready_i = 0;
        push_one(rand_instr(), 32'h400);
        push_one(rand_instr(), 32'h404);
        rst_i = 1;
        tick();
        rst_i = 0;
        n_checks++; if (out_valid_o !== 1'b0 || in_ready_o !== 1'b1) begin n_fail++; $display("FAIL rstmid_state: got valid=%b ready=%b want 0 1", out_valid_o, in_ready_o); end
        n_checks++; if (obs_en !== 10'b0) begin n_fail++; $display("FAIL rstmid_enables: got %b want 0", obs_en); end
        push_one(x, 32'h408);
        n_checks++; if (out_valid_o !== 1'b1 || instr_o !== x) begin n_fail++; $display("FAIL rstmid_push: got valid=%b instr=%h want 1 %h", out_valid_o, instr_o, x); end
        out_ready_i = 1; tick(); out_ready_i = 0;
    endtask

    task automatic test_random();
        exp_t e;
        for (int i = 0; i < 1500; i++) begin
            n_checks++; if (out_valid_o !== (q.size() != 0)) begin n_fail++; $display("FAIL rnd_valid[%0d]: got %b want %b", i, out_valid_o, q.size() != 0); end
            n_checks++; if (in_ready_o !== (q.size() != DEPTH)) begin n_fail++; $display("FAIL rnd_ready[%0d]: got %b want %b", i, in_ready_o, q.size() != DEPTH); end
            if (q.size() != 0) begin
                e = ref_decode(q[0].instr);
                n_checks++; if (instr_o !== q[0].instr || pc_o !== q[0].pc) begin
                    n_fail++; $display("FAIL rnd_head[%0d]: got %h/%h want %h/%h", i, instr_o, pc_o, q[0].instr, q[0].pc); end
                n_checks++; if (obs_all !== exp_all(e)) begin
                    n_fail++; $display("FAIL rnd_bundle[%0d] instr %h: got %h want %h", i, q[0].instr, obs_all, exp_all(e)); end
            end else begin
                n_checks++; if (obs_en !== 10'b0) begin n_fail++; $display("FAIL rnd_idle_en[%0d]: got %b want 0", i, obs_en); end
            end
            rst_i       = ($urandom_range(0, 99) == 0);
            flush_i     = ($urandom_range(0, 19) == 0);
            in_valid_i  = ($urandom_range(0, 3) != 0);
            out_ready_i = ($urandom_range(0, 2) != 0);
            instr_i     = rand_instr();
            pc_i        = $urandom;
            tick();
        end
        rst_i = 0; flush_i = 0; in_valid_i = 0; out_ready_i = 0;
    endtask

    initial begin
        test_reset();
        test_add();
        test_mul();
        test_full_order();
        test_flush();
        test_system();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/decode_stage_riscv.md
DECODE_STAGE_RISCV -- requirements
Module: decode_stage_riscv

Interface
REQ-001 Parameter DEPTH, default 2, sets the number of decoded-instruction buffer entries; it SHALL be a power of two and at least 2.
REQ-002 clk_i  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 rst_i  input  1  SHALL be the reset: synchronous, active-high.
REQ-004 instr_i  input  32  SHALL carry the fetched instruction word.
REQ-005 pc_i  input  32  SHALL carry the PC of instr_i.
REQ-006 in_valid_i / in_ready_o  input / output  1 / 1  SHALL form the upstream handshake; a push occurs when both are high.
REQ-007 flush_i  input  1  SHALL discard all buffered entries.
REQ-008 out_valid_o / out_ready_i  output / input  1 / 1  SHALL form the downstream handshake; a pop occurs when both are high.
REQ-009 instr_o, pc_o  output  32 each  SHALL carry the head entry's instruction and PC.
REQ-010 a_sel_o 2, b_sel_o 3, alu_op_o 5, csr_op_o 3, mem_size_o 3, wb_sel_o 2  output  SHALL carry the head entry's decoded fields, encoded per alu_opcodes_pkg, csr_pkg and riscv_pkg.
REQ-011 csr_we_o, mem_req_o, mem_we_o, gpr_we_o, illegal_instr_o, branch_o, jal_o, jalr_o, mret_o, mdu_req_o  output  1 each  SHALL carry the head entry's decoded enables.
REQ-012 mdu_op_o  output  3  SHALL carry the head entry's multiply/divide operation (funct3).

Function
REQ-013 Decode SHALL be combinational on instr_i at push time; the full decoded bundle, instr_i and pc_i SHALL be stored in the entry.
REQ-014 Decoded ISA: RV32I, Zicsr and mret.
- Legal load funct3: 0,1,2,4,5.
- Legal store funct3: 0,1,2.
- OP: funct7=0 for all funct3; funct7=0x20 only with funct3 0 or 5.
- OP-IMM shifts: funct7=0; SRAI uses 0x20.
- Branch: funct3 2 and 3 illegal.
- JALR and MISC-MEM: funct3=0 only.
- SYSTEM: funct3=0 legal only as mret (funct7=0x18); funct3=4 illegal.
- Any opcode with bits[1:0]!=2'b11 is illegal.
REQ-015 An illegal instruction SHALL store illegal_instr_o=1 with all other enables 0; selects SHALL default to RS1, IMM_I, ADD, CSR_RW, LDST_B, WB_EX_RESULT.
REQ-016 Latency: an entry pushed in cycle N SHALL be presented no earlier than cycle N+1; there is no combinational path from instr_i to any output.
REQ-017 in_ready_o SHALL equal (count != DEPTH) and SHALL NOT depend on out_ready_i.
REQ-018 out_valid_o SHALL equal (count != 0).
REQ-019 While out_valid_o=0, every enable output in REQ-011 SHALL be 0.
REQ-020 While out_valid_o=1 and out_ready_i=0, all outputs SHALL hold stable.
REQ-021 Simultaneous push and pop SHALL leave the count unchanged and preserve FIFO order; read and write pointers SHALL wrap modulo DEPTH.
REQ-022 When flush_i=1, the next cycle SHALL have count=0; any push or pop in the flush cycle SHALL be ignored, and flush has priority over both.

Reset
REQ-023 On rst_i=1, count and pointers SHALL be 0, out_valid_o=0, in_ready_o=1 from the following cycle, and all enable outputs 0.
REQ-024 Reset asserted mid-operation SHALL drop all buffered entries with no pop reported; stored payload contents need not be cleared.

Configuration
REQ-025 When RV32M_EN is defined, OP with funct7=0x01 SHALL be legal and SHALL decode to mdu_req_o=1, gpr_we_o=1, mdu_op_o=funct3, b_sel_o=RS2; when RV32M_EN is undefined, that encoding SHALL be illegal and mdu_req_o/mdu_op_o SHALL be tied to 0.

Verification
REQ-026 Push 0x002081B3 (add) with out_ready_i=1 -> next cycle out_valid_o=1, gpr_we_o=1, b_sel_o=RS2, alu_op_o=ALU_ADD, pc_o=pc_i.
REQ-027 Push 0x022081B3 (mul) -> with RV32M_EN: mdu_req_o=1, mdu_op_o=0, illegal_instr_o=0; without RV32M_EN: illegal_instr_o=1, gpr_we_o=0.
REQ-028 DEPTH=2, out_ready_i=0, push 3 consecutive instructions -> in_ready_o=0 after the 2nd push, 3rd not accepted; raising out_ready_i pops entries in order.
REQ-029 Full buffer, flush_i=1 in the same cycle as out_ready_i=1 -> next cycle out_valid_o=0, in_ready_o=1; no entry is delivered.
REQ-030 Push 0x30200073 (mret) then 0x00004073 (SYSTEM, funct3=4) -> first entry gives mret_o=1; second gives illegal_instr_o=1, csr_we_o=0.
REQ-031 Two entries buffered, assert rst_i for 1 cycle -> next cycle out_valid_o=0 with all enables 0; the following push appears after 1 cycle.
